uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Frame-sequencing FSM for the UART receiver. It drives the edge/bit counter's enable and clear, and times the data sampler, deserializer and the parity, start and stop checkers. It gates DATA_VALID on the checker results. It sits between the synchronised RX_IN line and the RX datapath sub-blocks, in the UART RX clock domain.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..12.

Ports:
CLK  input  1  RX-domain clock (oversampled, PRESCALE x baud)
RST  input  1  asynchronous reset, active-low
RX_IN  input  1  serial line, already synchronised, idle high
PAR_EN  input  1  1 = frame carries a parity bit
PRESCALE  input  6  oversampling ratio; only 8, 16, 32 legal
EDGE_COUNT  input  5  from edge/bit counter
BIT_COUNT  input  4  from edge/bit counter
STRT_GLITCH  input  1  start checker result, valid the same cycle as STRT_CHK_EN
PAR_ERR  input  1  parity checker result, valid the same cycle as PAR_CHK_EN
STP_ERR  input  1  stop checker result, valid the same cycle as STP_CHK_EN
CNT_EN  output  1  counter enable
COUNT_RST  output  1  counter clear, active-low (0 = clear)
SAMPLE_EN  output  1  sampler enable (majority-of-3 window)
DESER_EN  output  1  shift the sampled bit into the deserializer
STRT_CHK_EN  output  1  start check strobe
PAR_CHK_EN  output  1  parity check strobe
STP_CHK_EN  output  1  stop check strobe
DATA_VALID  output  1  registered, 1-cycle pulse: good frame received

Behaviour:
- Reset: RST low at any time, including mid-frame, forces IDLE asynchronously. All outputs are 0; COUNT_RST=0 (counter held clear). The parity-error latch is cleared.
- Decodes (combinational):
  - last_edge = (EDGE_COUNT == PRESCALE-1)
  - mid = PRESCALE/2
  - sample window = EDGE_COUNT in {mid-1, mid, mid+1}
- States: IDLE, START, DATA, PARITY, STOP. All outputs except DATA_VALID are combinational from state and decodes (Moore plus counter decode).
- IDLE:
  - Outputs: CNT_EN=0, COUNT_RST=0, all strobes 0.
  - Go to START when RX_IN==0 and PRESCALE is legal. An illegal PRESCALE keeps the block in IDLE indefinitely.
  - The parity latch is cleared in IDLE.
- START, DATA, PARITY, STOP common outputs: CNT_EN=1, COUNT_RST=1, SAMPLE_EN=1 inside the sample window. On entry to START, EDGE_COUNT=0 and BIT_COUNT=0.
- START:
  - STRT_CHK_EN=1 on last_edge.
  - On last_edge: STRT_GLITCH=1 -> IDLE (frame dropped, no DATA_VALID); otherwise -> DATA.
- DATA:
  - DESER_EN=1 on last_edge, exactly DATA_WIDTH pulses per frame.
  - On last_edge with BIT_COUNT==DATA_WIDTH: go to PARITY if PAR_EN=1, else STOP.
- PARITY:
  - PAR_CHK_EN=1 on last_edge; PAR_ERR is latched at that edge.
  - On last_edge -> STOP.
- STOP:
  - STP_CHK_EN=1 on last_edge.
  - On last_edge -> IDLE.
  - DATA_VALID is registered high on the next cycle iff STP_ERR==0 and the parity latch==0.
- Back-to-back frames: the IDLE cycle after STOP samples RX_IN. A low RX_IN there re-enters START with one cycle of skew, which is within sampling tolerance.
- PAR_EN and PRESCALE are sampled on every cycle. Changing them mid-frame is illegal and the result is undefined. Changing them in IDLE is safe.
- Frame length in non-IDLE cycles = PRESCALE x (DATA_WIDTH + 2 + PAR_EN).

Optional Feature:
- Macro: UART_RX_ERR_FLAGS_EN.
- Defined: adds outputs PAR_ERR_FLAG and STP_ERR_FLAG (1 bit each). Each is a registered 1-cycle pulse the cycle after the corresponding checker strobe reports an error. STRT_GLITCH aborts remain silent.
- Undefined: these ports do not exist; errors only suppress DATA_VALID.

Decomposition:
- Shared package uart_rx_pkg holds:
  - state encoding enum (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit)
  - legal PRESCALE constants 8/16/32
  - counter widths 5/4
- No sub-module; the decode logic is small enough to stay inline.

Test Plan:
- PRESCALE=8, PAR_EN=1, even parity, byte 0xA5, clean stop -> 8 DESER_EN pulses. DATA_VALID is high for exactly 1 cycle, 89 cycles after the edge at which IDLE sampled RX_IN=0.
- PRESCALE=16, PAR_EN=0, two back-to-back 0x3C frames -> two DATA_VALID pulses 161 cycles apart. No PAR_CHK_EN ever asserted.
- 3-cycle low glitch on RX_IN with PRESCALE=8 (checker returns STRT_GLITCH=1) -> return to IDLE after 8 cycles. No DESER_EN, no DATA_VALID.
- PRESCALE=32, PAR_ERR=1 at the parity strobe -> frame completes, DATA_VALID stays 0. PAR_ERR_FLAG pulses when UART_RX_ERR_FLAGS_EN is defined.
- STP_ERR=1 at the stop strobe -> DATA_VALID 0. The next clean frame produces DATA_VALID normally, proving the latch cleared.
- RST asserted mid-DATA (BIT_COUNT=4) -> all outputs 0 immediately. After release, a full valid frame is received correctly. PRESCALE=10 in IDLE -> no state change while RX_IN toggles.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } rx_state_e;

  localparam logic [5:0] Prescale8  = 6'd8;
  localparam logic [5:0] Prescale16 = 6'd16;
  localparam logic [5:0] Prescale32 = 6'd32;

  localparam int unsigned EdgeCntW = 5;
  localparam int unsigned BitCntW  = 4;

  function automatic logic is_legal_prescale(input logic [5:0] prescale);
    return (prescale == Prescale8) || (prescale == Prescale16) || (prescale == Prescale32);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl.sv
// UART RX frame-sequencing FSM: drives the edge/bit counter and times sampler and checkers.
// Optional error-flag outputs are built when UART_RX_ERR_FLAGS_EN is defined.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RX_IN,
  input  logic                PAR_EN,
  input  logic [5:0]          PRESCALE,
  input  logic [EdgeCntW-1:0] EDGE_COUNT,
  input  logic [BitCntW-1:0]  BIT_COUNT,
  input  logic                STRT_GLITCH,
  input  logic                PAR_ERR,
  input  logic                STP_ERR,
  output logic                CNT_EN,
  output logic                COUNT_RST,
  output logic                SAMPLE_EN,
  output logic                DESER_EN,
  output logic                STRT_CHK_EN,
  output logic                PAR_CHK_EN,
  output logic                STP_CHK_EN,
`ifdef UART_RX_ERR_FLAGS_EN
  output logic                PAR_ERR_FLAG,
  output logic                STP_ERR_FLAG,
`endif
  output logic                DATA_VALID
);

  rx_state_e  r_state;
  logic       r_par_err;
  logic       r_data_valid;
  logic [5:0] w_edge_ext;
  logic [5:0] w_mid;
  logic       w_last_edge;
  logic       w_in_window;
  logic       w_last_data;

  assign w_edge_ext  = {1'b0, EDGE_COUNT};
  assign w_mid       = PRESCALE >> 1;
  assign w_last_edge = (w_edge_ext == (PRESCALE - 6'd1));
  // Window is mid-1..mid+1, written without subtraction to avoid underflow.
  assign w_in_window = ((w_edge_ext + 6'd1) >= w_mid) && (w_edge_ext <= (w_mid + 6'd1));
  assign w_last_data = (BIT_COUNT == BitCntW'(DATA_WIDTH));

`ifdef UART_RX_ERR_FLAGS_EN
  logic r_par_flag;
  logic r_stp_flag;
  assign PAR_ERR_FLAG = r_par_flag;
  assign STP_ERR_FLAG = r_stp_flag;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= StIdle;
      r_par_err    <= 1'b0;
      r_data_valid <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
      r_par_flag   <= 1'b0;
      r_stp_flag   <= 1'b0;
`endif
    end else begin
      r_data_valid <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
      r_par_flag   <= 1'b0;
      r_stp_flag   <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          r_par_err <= 1'b0;
          if (!RX_IN && is_legal_prescale(PRESCALE)) r_state <= StStart;
        end
        StStart: begin
          if (w_last_edge) r_state <= STRT_GLITCH ? StIdle : StData;
        end
        StData: begin
          if (w_last_edge && w_last_data) r_state <= PAR_EN ? StParity : StStop;
        end
        StParity: begin
          if (w_last_edge) begin
            r_par_err <= PAR_ERR;
            r_state   <= StStop;
`ifdef UART_RX_ERR_FLAGS_EN
            r_par_flag <= PAR_ERR;
`endif
          end
        end
        StStop: begin
          if (w_last_edge) begin
            r_state      <= StIdle;
            r_data_valid <= !STP_ERR && !r_par_err;
`ifdef UART_RX_ERR_FLAGS_EN
            r_stp_flag   <= STP_ERR;
`endif
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    CNT_EN      = 1'b0;
    COUNT_RST   = 1'b0;
    SAMPLE_EN   = 1'b0;
    DESER_EN    = 1'b0;
    STRT_CHK_EN = 1'b0;
    PAR_CHK_EN  = 1'b0;
    STP_CHK_EN  = 1'b0;
    if (r_state != StIdle) begin
      CNT_EN    = 1'b1;
      COUNT_RST = 1'b1;
      SAMPLE_EN = w_in_window;
    end
    unique case (r_state)
      StStart:  STRT_CHK_EN = w_last_edge;
      StData:   DESER_EN    = w_last_edge;
      StParity: PAR_CHK_EN  = w_last_edge;
      StStop:   STP_CHK_EN  = w_last_edge;
      default:  ;
    endcase
  end

  assign DATA_VALID = r_data_valid;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: behavioural frame-timing model plus an edge/bit counter.
module tb_uart_rx_ctrl;

  localparam int DW = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] PRESCALE = 6'd8;
  logic [4:0] EDGE_COUNT;
  logic [3:0] BIT_COUNT;
  logic       STRT_GLITCH = 1'b0;
  logic       PAR_ERR = 1'b0;
  logic       STP_ERR = 1'b0;
  logic       CNT_EN, COUNT_RST, SAMPLE_EN, DESER_EN;
  logic       STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN, DATA_VALID;
`ifdef UART_RX_ERR_FLAGS_EN
  logic       PAR_ERR_FLAG, STP_ERR_FLAG;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .PRESCALE    (PRESCALE),
    .EDGE_COUNT  (EDGE_COUNT),
    .BIT_COUNT   (BIT_COUNT),
    .STRT_GLITCH (STRT_GLITCH),
    .PAR_ERR     (PAR_ERR),
    .STP_ERR     (STP_ERR),
    .CNT_EN      (CNT_EN),
    .COUNT_RST   (COUNT_RST),
    .SAMPLE_EN   (SAMPLE_EN),
    .DESER_EN    (DESER_EN),
    .STRT_CHK_EN (STRT_CHK_EN),
    .PAR_CHK_EN  (PAR_CHK_EN),
    .STP_CHK_EN  (STP_CHK_EN),
`ifdef UART_RX_ERR_FLAGS_EN
    .PAR_ERR_FLAG(PAR_ERR_FLAG),
    .STP_ERR_FLAG(STP_ERR_FLAG),
`endif
    .DATA_VALID  (DATA_VALID)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Environment: the edge/bit counter the controller drives.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      EDGE_COUNT <= '0;
      BIT_COUNT  <= '0;
    end else if (!COUNT_RST) begin
      EDGE_COUNT <= '0;
      BIT_COUNT  <= '0;
    end else if (CNT_EN) begin
      if ({1'b0, EDGE_COUNT} == PRESCALE - 6'd1) begin
        EDGE_COUNT <= '0;
        BIT_COUNT  <= BIT_COUNT + 4'd1;
      end else begin
        EDGE_COUNT <= EDGE_COUNT + 5'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {CNT_EN, COUNT_RST, SAMPLE_EN, DESER_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN,
            DATA_VALID};
  endfunction

  // Expected outputs k cycles into a frame, from bit slot k/p and edge position k%p.
  function automatic logic [7:0] exp_out(input int p, input bit pen, input int k);
    int  b    = k / p;
    int  e    = k % p;
    int  mid  = p / 2;
    bit  last = (e == p - 1);
    bit  samp = (e >= mid - 1) && (e <= mid + 1);
    bit  st   = (b == 0);
    bit  dt   = (b >= 1) && (b <= DW);
    bit  pr   = pen && (b == DW + 1);
    bit  sp   = !st && !dt && !pr;
    return {1'b1, 1'b1, samp, dt && last, st && last, pr && last, sp && last, 1'b0};
  endfunction

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK); #1;
      check("idle_cnt_en", 32'(CNT_EN), 32'd0);
    end
  endtask

  // Entered #1 after a posedge with the DUT in IDLE; returns #1 after the edge ending the frame.
  task automatic run_frame(input int p, input bit pen, input logic [DW-1:0] data,
                           input bit glitch, input bit perr, input bit serr, input int abort_k,
                           output int start_c, output int dv_c);
    int nbits = glitch ? 1 : DW + 2 + int'(pen);
    int len   = p * nbits;
    int nd    = 0;
    bit exp_dv = !glitch && !(pen && perr) && !serr;
    start_c = -1;
    dv_c    = -1;
    PRESCALE = 6'(p); PAR_EN = pen; STRT_GLITCH = glitch; PAR_ERR = perr; STP_ERR = serr;
    RX_IN = 1'b0;
    @(posedge CLK); #1;
    start_c = cyc;
    for (int k = 0; k < len; k++) begin
      int b = k / p;
      check($sformatf("frame_p%0d_k%0d", p, k), 32'(outs()), 32'(exp_out(p, pen, k)));
      nd += int'(DESER_EN);
      if (k == abort_k) begin
        RST = 1'b0; #1;
        check("rst_async_outs", 32'(outs()), 32'd0);
        @(posedge CLK); #1;
        check("rst_held_outs", 32'(outs()), 32'd0);
        @(negedge CLK); RST = 1'b1; RX_IN = 1'b1;
        @(posedge CLK); #1;
        return;
      end
      if (glitch)           RX_IN = (k < 2) ? 1'b0 : 1'b1;
      else if (b == 0)      RX_IN = 1'b0;
      else if (b <= DW)     RX_IN = data[b-1];
      else if (pen && b == DW + 1) RX_IN = ^data;
      else                  RX_IN = 1'b1;
      @(posedge CLK); #1;
    end
    check("frame_dv", 32'(DATA_VALID), 32'(exp_dv));
    check("frame_end_idle", 32'({CNT_EN, COUNT_RST}), 32'd0);
    check("deser_pulses", 32'(nd), glitch ? 32'd0 : 32'(DW));
`ifdef UART_RX_ERR_FLAGS_EN
    check("par_err_flag", 32'(PAR_ERR_FLAG), 32'(!glitch && pen && perr));
    check("stp_err_flag", 32'(STP_ERR_FLAG), 32'(!glitch && serr));
`endif
    if (DATA_VALID) dv_c = cyc;
    RX_IN = 1'b1;
  endtask

  initial begin
    int s1, d1, s2, d2;
    // Reset state
    #3;
    check("reset_outs", 32'(outs()), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    check("post_reset_idle", 32'(outs()), 32'd0);

    // P=8 with parity, 0xA5: DV lands in the 89th cycle counted from the start edge
    run_frame(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, -1, s1, d1);
    check("dv_latency_p8", 32'(d1 - s1 + 1), 32'd89);
    idle(1);
    check("dv_one_cycle", 32'(DATA_VALID), 32'd0);
    idle(2);

    // Back-to-back frames at P=16, no parity
    run_frame(16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, s1, d1);
    run_frame(16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, s2, d2);
    check("b2b_dv_gap", 32'(d2 - d1), 32'd161);
    idle(3);

    // Start glitch: aborted after one bit slot
    run_frame(8, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, -1, s1, d1);
    idle(4);

    // Parity error at P=32
    run_frame(32, 1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0, -1, s1, d1);
    idle(2);

    // Stop error, then a clean frame
    run_frame(16, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1, -1, s1, d1);
    idle(2);
    run_frame(16, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, -1, s1, d1);
    idle(2);

    // Reset mid-DATA with BIT_COUNT=4, then a full frame
    run_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 4 * 8 + 3, s1, d1);
    check("after_rst_idle", 32'(outs()), 32'd0);
    run_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, -1, s1, d1);
    idle(2);

    // Illegal prescale: no frame starts while RX_IN toggles
    PRESCALE = 6'd10;
    for (int i = 0; i < 20; i++) begin
      RX_IN = i[0];
      @(posedge CLK); #1;
      check("illegal_prescale", 32'({CNT_EN, COUNT_RST}), 32'd0);
    end
    RX_IN = 1'b1;
    idle(2);

    // Randomized frames
    for (int i = 0; i < 10; i++) begin
      int p;
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      run_frame(p, 1'($urandom), 8'($urandom), 1'b0, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), -1, s1, d1);
      idle($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
